// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences MDR word reads/writes and MBR byte fetches onto one single-port RAM.
// Optional build macro MEM_QUEUE_EN adds a one-entry holding register for requests arriving while busy.
module mem_ctrl #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned MEM   = 3,
  parameter int unsigned ADDR  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MEM-1:0]   mem_control,
  input  logic [NBITS-1:0] mar,
  input  logic [NBITS-1:0] mdr,
  input  logic [NBITS-1:0] pc,
  output logic             ready,
  output logic [NBITS-1:0] mdr_data,
  output logic             mdr_valid,
  output logic [7:0]       mbr_data,
  output logic             mbr_valid,
  output logic             err,
  output logic [ADDR-1:0]  ram_addr,
  output logic [NBITS-1:0] ram_data,
  output logic             ram_we,
  input  logic [NBITS-1:0] ram_q
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, FT_A, FT_D} state_e;

  state_e           state_q, state_d;
  logic             fetch_pend_q, fetch_pend_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [ADDR-1:0]  ram_addr_q, ram_addr_d;
  logic [NBITS-1:0] ram_data_q, ram_data_d;
  logic [NBITS-1:0] mdr_data_q, mdr_data_d;
  logic             mdr_valid_q, mdr_valid_d;
  logic [7:0]       mbr_data_q, mbr_data_d;
  logic             mbr_valid_q, mbr_valid_d;
  logic             err_q, err_d;

  logic [MEM-1:0]   acc_ctl;
  logic [NBITS-1:0] acc_mar, acc_mdr, acc_pc;
  logic [7:0]       byte_sel;
  logic             hold_full;
  logic             unused_addr_bits;

`ifdef MEM_QUEUE_EN
  logic             hold_valid_q, hold_valid_d;
  logic [MEM-1:0]   hold_ctl_q, hold_ctl_d;
  logic [NBITS-1:0] hold_mar_q, hold_mar_d;
  logic [NBITS-1:0] hold_mdr_q, hold_mdr_d;
  logic [NBITS-1:0] hold_pc_q, hold_pc_d;

  assign hold_full = hold_valid_q;
`else
  assign hold_full = 1'b0;
`endif

  assign ready     = (state_q == IDLE) && !hold_full;
  assign mdr_data  = mdr_data_q;
  assign mdr_valid = mdr_valid_q;
  assign mbr_data  = mbr_data_q;
  assign mbr_valid = mbr_valid_q;
  assign err       = err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  // Combinational so a reset landing on the write cycle suppresses the write immediately.
  assign ram_we    = (state_q == WR) && !reset;

  assign unused_addr_bits = ^{acc_mar[NBITS-1:ADDR], pc_q[NBITS-1:ADDR+2]};

  // A held request takes priority over the live port when returning to IDLE.
  always_comb begin
    acc_ctl = mem_control;
    acc_mar = mar;
    acc_mdr = mdr;
    acc_pc  = pc;
`ifdef MEM_QUEUE_EN
    if (hold_valid_q) begin
      acc_ctl = hold_ctl_q;
      acc_mar = hold_mar_q;
      acc_mdr = hold_mdr_q;
      acc_pc  = hold_pc_q;
    end
`endif
  end

  always_comb begin
    case (pc_q[1:0])
      2'd0:    byte_sel = ram_q[7:0];
      2'd1:    byte_sel = ram_q[15:8];
      2'd2:    byte_sel = ram_q[23:16];
      default: byte_sel = ram_q[31:24];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fetch_pend_d = fetch_pend_q;
    pc_d         = pc_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    mdr_data_d   = mdr_data_q;
    mdr_valid_d  = 1'b0;
    mbr_data_d   = mbr_data_q;
    mbr_valid_d  = 1'b0;
    err_d        = 1'b0;
`ifdef MEM_QUEUE_EN
    hold_valid_d = hold_valid_q;
    hold_ctl_d   = hold_ctl_q;
    hold_mar_d   = hold_mar_q;
    hold_mdr_d   = hold_mdr_q;
    hold_pc_d    = hold_pc_q;
    if (state_q == IDLE) hold_valid_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (acc_ctl != '0) begin
          pc_d = acc_pc;
          if (acc_ctl[2]) begin
            // Write wins over a simultaneous read; the read is reported as dropped.
            state_d      = WR;
            ram_addr_d   = acc_mar[ADDR-1:0];
            ram_data_d   = acc_mdr;
            fetch_pend_d = acc_ctl[0];
            err_d        = acc_ctl[1];
          end else if (acc_ctl[1]) begin
            state_d      = RD_A;
            ram_addr_d   = acc_mar[ADDR-1:0];
            fetch_pend_d = acc_ctl[0];
          end else begin
            state_d      = FT_A;
            ram_addr_d   = acc_pc[ADDR+1:2];
            fetch_pend_d = 1'b0;
          end
        end
      end
      RD_A: state_d = RD_D;
      RD_D, WR: begin
        if (state_q == RD_D) begin
          mdr_data_d  = ram_q;
          mdr_valid_d = 1'b1;
        end
        if (fetch_pend_q) begin
          state_d      = FT_A;
          ram_addr_d   = pc_q[ADDR+1:2];
          fetch_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FT_A: state_d = FT_D;
      FT_D: begin
        mbr_data_d  = byte_sel;
        mbr_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((mem_control != '0) && !ready) begin
`ifdef MEM_QUEUE_EN
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_ctl_d   = mem_control;
        hold_mar_d   = mar;
        hold_mdr_d   = mdr;
        hold_pc_d    = pc;
      end else begin
        err_d = 1'b1;
      end
`else
      err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pend_q <= 1'b0;
      pc_q         <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      mdr_data_q   <= '0;
      mdr_valid_q  <= 1'b0;
      mbr_data_q   <= '0;
      mbr_valid_q  <= 1'b0;
      err_q        <= 1'b0;
`ifdef MEM_QUEUE_EN
      hold_valid_q <= 1'b0;
      hold_ctl_q   <= '0;
      hold_mar_q   <= '0;
      hold_mdr_q   <= '0;
      hold_pc_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_pend_d;
      pc_q         <= pc_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      mdr_data_q   <= mdr_data_d;
      mdr_valid_q  <= mdr_valid_d;
      mbr_data_q   <= mbr_data_d;
      mbr_valid_q  <= mbr_valid_d;
      err_q        <= err_d;
`ifdef MEM_QUEUE_EN
      hold_valid_q <= hold_valid_d;
      hold_ctl_q   <= hold_ctl_d;
      hold_mar_q   <= hold_mar_d;
      hold_mdr_q   <= hold_mdr_d;
      hold_pc_q    <= hold_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand sequences, randomized schedule model.
module tb_mem_ctrl;
  localparam int NBITS = 32;
  localparam int MEM   = 3;
  localparam int ADDR  = 10;
  localparam int NRND  = 150;

  logic              clk = 1'b0;
  logic              reset;
  logic [MEM-1:0]    mem_control;
  logic [NBITS-1:0]  mar, mdr, pc;
  logic              ready, mdr_valid, mbr_valid, err, ram_we;
  logic [NBITS-1:0]  mdr_data, ram_data;
  logic [NBITS-1:0]  ram_q = '0;
  logic [7:0]        mbr_data;
  logic [ADDR-1:0]   ram_addr;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  logic [31:0] ram [0:1023];

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] mar, mdr, pc;
    int          mdr_at;
    logic [31:0] mdr_exp;
    int          mbr_at;
    logic [7:0]  mbr_exp;
    int          err_at;
    int          busy;
  } vec_t;
  vec_t vecs [11];
  vec_t vx;

  // random-phase reference model: word contents plus expected strobes keyed by cycle
  logic [31:0] ref_mem [32];
  logic [31:0] exp_mdr [int];
  logic [7:0]  exp_mbr [int];
  bit          exp_err [int];
  int          next_free, ops_done, gap, t, idx, pidx, bsel;
  bit          exp_rdy;
  logic [2:0]  c;
  logic [31:0] wd;

  mem_ctrl #(.NBITS(NBITS), .MEM(MEM), .ADDR(ADDR)) dut (
    .clk(clk), .reset(reset), .mem_control(mem_control), .mar(mar), .mdr(mdr), .pc(pc),
    .ready(ready), .mdr_data(mdr_data), .mdr_valid(mdr_valid), .mbr_data(mbr_data),
    .mbr_valid(mbr_valid), .err(err), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data;
    ram_q <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_control = '0;
    mar = $urandom;
    mdr = $urandom;
    pc  = $urandom;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_b({tag, " ready"}, ready, 1'b1);
    chk({tag, " mdr_data"}, mdr_data, 32'h0);
    chk_b({tag, " mdr_valid"}, mdr_valid, 1'b0);
    chk({tag, " mbr_data"}, 32'(mbr_data), 32'h0);
    chk_b({tag, " mbr_valid"}, mbr_valid, 1'b0);
    chk_b({tag, " err"}, err, 1'b0);
    chk({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
    chk({tag, " ram_data"}, ram_data, 32'h0);
    chk_b({tag, " ram_we"}, ram_we, 1'b0);
  endtask

  function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] p, input int ma, input logic [31:0] me,
                              input int ba, input logic [7:0] be, input int ea, input int busy);
    vec_t v;
    v.ctl = ctl; v.mar = a; v.mdr = d; v.pc = p;
    v.mdr_at = ma; v.mdr_exp = me; v.mbr_at = ba; v.mbr_exp = be;
    v.err_at = ea; v.busy = busy;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = (v.ctl[2] || v.ctl[1]) ? 32'(v.mar[9:0]) : 32'(v.pc[11:2]);
    next_cycle();
    mem_control = v.ctl; mar = v.mar; mdr = v.mdr; pc = v.pc;
    @(negedge clk);
    chk_b($sformatf("v%0d ready@T", i), ready, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk_b($sformatf("v%0d ready@%0d", i, k), ready, !(k <= v.busy));
      chk_b($sformatf("v%0d mdr_valid@%0d", i, k), mdr_valid, k == v.mdr_at);
      if (k == v.mdr_at) chk($sformatf("v%0d mdr_data", i), mdr_data, v.mdr_exp);
      chk_b($sformatf("v%0d mbr_valid@%0d", i, k), mbr_valid, k == v.mbr_at);
      if (k == v.mbr_at) chk($sformatf("v%0d mbr_data", i), 32'(mbr_data), 32'(v.mbr_exp));
      chk_b($sformatf("v%0d err@%0d", i, k), err, k == v.err_at);
      chk_b($sformatf("v%0d ram_we@%0d", i, k), ram_we, (k == 1) && v.ctl[2]);
      if (k == 1) chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), exp_addr);
      if (k == 1 && v.ctl[2]) chk($sformatf("v%0d ram_data", i), ram_data, v.mdr);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    reset = 1'b1;
    idle_inputs();

    //            ctl     mar           mdr           pc            mdr@ mdr_exp       mbr@ mbr   err busy
    vecs[0]  = mk(3'b100, 32'd5,        32'hDEADBEEF, 32'd0,        0, 32'h0,        0, 8'h00, 0, 1);
    vecs[1]  = mk(3'b010, 32'd5,        32'h0,        32'd0,        3, 32'hDEADBEEF, 0, 8'h00, 0, 2);
    vecs[2]  = mk(3'b100, 32'd2,        32'h44332211, 32'd0,        0, 32'h0,        0, 8'h00, 0, 1);
    vecs[3]  = mk(3'b001, 32'd0,        32'h0,        32'd9,        0, 32'h0,        3, 8'h22, 0, 2);
    vecs[4]  = mk(3'b011, 32'd2,        32'h0,        32'd11,       3, 32'h44332211, 5, 8'h44, 0, 4);
    vecs[5]  = mk(3'b110, 32'd3,        32'h12,       32'd0,        0, 32'h0,        0, 8'h00, 1, 1);
    vecs[6]  = mk(3'b010, 32'd3,        32'h0,        32'd0,        3, 32'h12,       0, 8'h00, 0, 2);
    vecs[7]  = mk(3'b101, 32'd7,        32'hA5A50F0F, 32'd8,        0, 32'h0,        4, 8'h11, 0, 3);
    vecs[8]  = mk(3'b001, 32'd0,        32'h0,        32'hFFFFF00B, 0, 32'h0,        3, 8'h44, 0, 2);
    vecs[9]  = mk(3'b010, 32'hABCDFC05, 32'h0,        32'd0,        3, 32'hDEADBEEF, 0, 8'h00, 0, 2);
    vecs[10] = mk(3'b010, 32'd7,        32'h0,        32'd0,        3, 32'hA5A50F0F, 0, 8'h00, 0, 2);

    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_reset_vals("reset");
    next_cycle();
    reset = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // request while busy: second read at T+1, fetch at T+2
    next_cycle();
    mem_control = 3'b010; mar = 32'd5;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      idle_inputs();
      if (k == 1) begin mem_control = 3'b010; mar = 32'd2; end
      if (k == 2) begin mem_control = 3'b001; pc = 32'd9; end
      @(negedge clk);
      chk_b($sformatf("busy mbr_valid@%0d", k), mbr_valid, 1'b0);
`ifdef MEM_QUEUE_EN
      chk_b($sformatf("busy ready@%0d", k), ready, !(k <= 5));
      chk_b($sformatf("busy err@%0d", k), err, k == 3);
      chk_b($sformatf("busy mdr_valid@%0d", k), mdr_valid, k == 3 || k == 6);
      if (k == 6) chk("busy queued mdr_data", mdr_data, 32'h44332211);
`else
      chk_b($sformatf("busy ready@%0d", k), ready, !(k <= 2));
      chk_b($sformatf("busy err@%0d", k), err, k == 2 || k == 3);
      chk_b($sformatf("busy mdr_valid@%0d", k), mdr_valid, k == 3);
`endif
      if (k == 3) chk("busy first mdr_data", mdr_data, 32'hDEADBEEF);
    end

    // reset during the write cycle suppresses the write
    next_cycle();
    mem_control = 3'b100; mar = 32'd9; mdr = 32'h77;
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk_b("wr-reset ram_we", ram_we, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("wr-reset");
    vx = mk(3'b010, 32'd9, 32'h0, 32'd0, 3, 32'h0, 0, 8'h00, 0, 2);
    run_vec(11, vx);

    // reset landing in RD_D
    next_cycle();
    mem_control = 3'b010; mar = 32'd5;
    next_cycle();
    idle_inputs();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk_b("rdd-reset mdr_valid in reset cycle", mdr_valid, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rdd-reset");
    next_cycle();
    @(negedge clk);
    chk_b("rdd-reset late mdr_valid", mdr_valid, 1'b0);

    // randomized: fill words 0..31, then random mixes; strobes predicted per absolute cycle
    next_cycle();
    idle_inputs();
    next_free = cyc;
    ops_done = 0;
    gap = 0;
    while ((ops_done < 32 + NRND || cyc < next_free + 6) && cyc < 20000) begin
      next_cycle();
      idle_inputs();
      exp_rdy = (cyc >= next_free);
      if (exp_rdy && gap == 0 && ops_done < 32 + NRND) begin
        if (ops_done < 32) begin
          c = 3'b100;
          idx = ops_done;
        end else begin
          c = 3'($urandom_range(1, 7));
          idx = int'($urandom_range(0, 31));
        end
        pidx = int'($urandom_range(0, 31));
        bsel = int'($urandom_range(0, 3));
        wd = $urandom;
        mem_control = c;
        mar = ($urandom << 10) | 32'(idx);
        mdr = wd;
        pc  = ($urandom << 12) | 32'(pidx << 2) | 32'(bsel);
        t = cyc;
        if (c[2]) begin
          ref_mem[idx] = wd;
          if (c[1]) exp_err[cyc + 1] = 1'b1;
          t = t + 1;
        end else if (c[1]) begin
          exp_mdr[cyc + 3] = ref_mem[idx];
          t = t + 2;
        end
        if (c[0]) begin
          exp_mbr[t + 3] = 8'(ref_mem[pidx] >> (8 * bsel));
          t = t + 2;
        end
        next_free = t + 1;
        ops_done++;
        gap = int'($urandom_range(0, 2));
      end else if (exp_rdy && gap > 0) begin
        gap--;
      end
      @(negedge clk);
      chk_b("rnd ready", ready, exp_rdy);
      chk_b("rnd mdr_valid", mdr_valid, exp_mdr.exists(cyc) != 0);
      if (exp_mdr.exists(cyc)) chk("rnd mdr_data", mdr_data, exp_mdr[cyc]);
      chk_b("rnd mbr_valid", mbr_valid, exp_mbr.exists(cyc) != 0);
      if (exp_mbr.exists(cyc)) chk("rnd mbr_data", 32'(mbr_data), 32'(exp_mbr[cyc]));
      chk_b("rnd err", err, exp_err.exists(cyc) != 0);
    end
    chk_b("rnd all ops issued", ops_done == 32 + NRND, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
